tm1638_bus_arbiter: RTL and testbench

TM1638_BUS_ARBITER -- requirements
Module: tm1638_bus_arbiter

---
 rtl/tm1638_pkg.sv | 23 ++
 rtl/tm1638_rr_arbiter.sv | 28 ++
 rtl/tm1638_bus_arbiter.sv | 193 +++++++++++++++++++
 tb/tb_tm1638_bus_arbiter.sv | 412 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tm1638_pkg.sv
// Shared types and constants for the TM1638 bus arbiter and its round-robin grant logic.
package tm1638_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_GAP,
        S_STB,
        S_CMD,
        S_DATA,
        S_WAIT,
        S_END
    } state_t;

    localparam int unsigned BYTE_W  = 8;
    localparam int unsigned LEN_W   = 5;
    localparam int unsigned MAX_LEN = 16;

    localparam logic [BYTE_W-1:0] CMD_READ_KEYS  = 8'h42;
    localparam logic [BYTE_W-1:0] CMD_WRITE_DISP = 8'h40;
    localparam logic [BYTE_W-1:0] CMD_ADDR0      = 8'hC0;
    localparam logic [BYTE_W-1:0] CMD_DISP_ON    = 8'h8F;

endpackage

// File: rtl/tm1638_rr_arbiter.sv
// Combinational round-robin picker: first active request at or after pointer, wrapping.
module tm1638_rr_arbiter #(
    parameter int unsigned n_req = 3
) (
    input  logic [n_req-1:0]         req,
    input  logic [$clog2(n_req)-1:0] pointer,
    output logic [n_req-1:0]         grant
);
    localparam int unsigned IDX_W = $clog2(n_req);

    int unsigned idx;
    logic        found;

    always_comb begin
        grant = '0;
        found = 1'b0;
        idx   = 0;
        for (int unsigned i = 0; i < n_req; i++) begin
            idx = 32'(pointer) + i;
            if (idx >= n_req) idx = idx - n_req;
            if (!found && req[IDX_W'(idx)]) begin
                grant[IDX_W'(idx)] = 1'b1;
                found              = 1'b1;
            end
        end
    end

endmodule

// File: rtl/tm1638_bus_arbiter.sv
// Shares one TM1638 byte engine among n_req frame requesters with round-robin grants.
// Defining TM1638_ARB_WDOG_EN builds a per-byte watchdog that aborts stuck frames.
module tm1638_bus_arbiter
    import tm1638_pkg::*;
#(
    parameter int unsigned clk_mhz     = 27,
    parameter int unsigned n_req       = 3,
    parameter int unsigned wdog_cycles = 1024
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [n_req-1:0]               req,
    input  logic [n_req-1:0][BYTE_W-1:0]   req_cmd,
    input  logic [n_req-1:0][LEN_W-1:0]    req_len,
    input  logic [n_req-1:0]               req_rd,
    input  logic [n_req-1:0][BYTE_W-1:0]   wr_data,
    output logic [n_req-1:0]               gnt,
    output logic                           wr_take,
    output logic [BYTE_W-1:0]              rd_data,
    output logic                           rd_valid,
    output logic                           done,
    output logic                           err,
    output logic                           sio_latch,
    output logic [BYTE_W-1:0]              sio_din,
    output logic                           sio_rw,
    input  logic                           sio_busy,
    input  logic [BYTE_W-1:0]              sio_dout,
    output logic                           sio_stb
);
    localparam int unsigned IDX_W   = $clog2(n_req);
    localparam int unsigned GAP_CYC = clk_mhz + 1;
    localparam int unsigned GAP_W   = $clog2(GAP_CYC + 1);

    if (n_req < 2 || n_req > 8 || wdog_cycles < 2) begin : g_bad_cfg
        $error("tm1638_bus_arbiter: n_req must be 2..8 and wdog_cycles at least 2");
    end

    state_t             state;
    logic [IDX_W-1:0]   ptr;
    logic [IDX_W-1:0]   gidx;
    logic [BYTE_W-1:0]  cmd_q;
    logic [LEN_W-1:0]   len_q;
    logic [LEN_W-1:0]   cnt;
    logic               rd_q;
    logic               busy_seen;
    logic [GAP_W-1:0]   gap_cnt;

    logic [n_req-1:0]   grant_c;
    logic [IDX_W-1:0]   grant_idx_c;
    logic [IDX_W-1:0]   next_ptr_c;
    logic [LEN_W-1:0]   len_sel_c;

    tm1638_rr_arbiter #(.n_req(n_req)) u_rr (
        .req     (req),
        .pointer (ptr),
        .grant   (grant_c)
    );

    // Winner index, pointer advance and length clamp so the byte counter never overruns.
    always_comb begin
        grant_idx_c = '0;
        for (int unsigned i = 0; i < n_req; i++) begin
            if (grant_c[IDX_W'(i)]) grant_idx_c = IDX_W'(i);
        end
        next_ptr_c = (grant_idx_c == IDX_W'(n_req - 1)) ? '0 : grant_idx_c + IDX_W'(1);
        len_sel_c  = req_len[grant_idx_c];
        if (len_sel_c > LEN_W'(MAX_LEN)) len_sel_c = LEN_W'(MAX_LEN);
    end

`ifdef TM1638_ARB_WDOG_EN
    localparam int unsigned WDOG_W = $clog2(wdog_cycles);
    logic [WDOG_W-1:0] wdog_cnt;
    logic              err_q;
    assign err = err_q;
`else
    assign err = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            ptr       <= '0;
            gidx      <= '0;
            cmd_q     <= '0;
            len_q     <= '0;
            cnt       <= '0;
            rd_q      <= 1'b0;
            busy_seen <= 1'b0;
            gap_cnt   <= GAP_W'(GAP_CYC);
            gnt       <= '0;
            wr_take   <= 1'b0;
            rd_data   <= '0;
            rd_valid  <= 1'b0;
            done      <= 1'b0;
            sio_latch <= 1'b0;
            sio_din   <= '0;
            sio_rw    <= 1'b1;
            sio_stb   <= 1'b1;
`ifdef TM1638_ARB_WDOG_EN
            wdog_cnt  <= '0;
            err_q     <= 1'b0;
`endif
        end else begin
            sio_latch <= 1'b0;
            wr_take   <= 1'b0;
            rd_valid  <= 1'b0;
            done      <= 1'b0;
`ifdef TM1638_ARB_WDOG_EN
            err_q     <= 1'b0;
`endif
            // Gap timer runs freely; END reloads it when STB returns high.
            if (gap_cnt != '0) gap_cnt <= gap_cnt - GAP_W'(1);

            case (state)
                S_IDLE: begin
                    if (|req) begin
                        gnt   <= grant_c;
                        gidx  <= grant_idx_c;
                        ptr   <= next_ptr_c;
                        cmd_q <= req_cmd[grant_idx_c];
                        len_q <= len_sel_c;
                        rd_q  <= req_rd[grant_idx_c];
                        cnt   <= '0;
                        state <= S_GAP;
                    end
                end
                S_GAP: begin
                    if (gap_cnt == '0) state <= S_STB;
                end
                S_STB: begin
                    sio_stb <= 1'b0;
                    sio_rw  <= 1'b1;
                    state   <= S_CMD;
                end
                S_CMD: begin
                    sio_latch <= 1'b1;
                    sio_din   <= cmd_q;
                    sio_rw    <= 1'b1;
                    busy_seen <= 1'b0;
`ifdef TM1638_ARB_WDOG_EN
                    wdog_cnt  <= '0;
`endif
                    state     <= S_WAIT;
                end
                S_DATA: begin
                    sio_latch <= 1'b1;
                    sio_din   <= rd_q ? '0 : wr_data[gidx];
                    sio_rw    <= ~rd_q;
                    wr_take   <= ~rd_q;
                    cnt       <= cnt + LEN_W'(1);
                    busy_seen <= 1'b0;
`ifdef TM1638_ARB_WDOG_EN
                    wdog_cnt  <= '0;
`endif
                    state     <= S_WAIT;
                end
                S_WAIT: begin
                    if (sio_busy) begin
                        busy_seen <= 1'b1;
                    end else if (busy_seen) begin
                        if (rd_q && cnt != '0) begin
                            rd_data  <= sio_dout;
                            rd_valid <= 1'b1;
                        end
                        state <= (cnt == len_q) ? S_END : S_DATA;
                    end
`ifdef TM1638_ARB_WDOG_EN
                    // Timeout overrides any exit this cycle: close the frame like END, minus done.
                    wdog_cnt <= wdog_cnt + WDOG_W'(1);
                    if (wdog_cnt == WDOG_W'(wdog_cycles - 1)) begin
                        sio_stb <= 1'b1;
                        sio_rw  <= 1'b1;
                        err_q   <= 1'b1;
                        gnt     <= '0;
                        gap_cnt <= GAP_W'(GAP_CYC);
                        state   <= S_IDLE;
                    end
`endif
                end
                S_END: begin
                    sio_stb <= 1'b1;
                    sio_rw  <= 1'b1;
                    done    <= 1'b1;
                    gnt     <= '0;
                    gap_cnt <= GAP_W'(GAP_CYC);
                    state   <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_tm1638_bus_arbiter.sv
// Scoreboard bench for tm1638_bus_arbiter with a behavioural byte engine and wr_data source.
module tb_tm1638_bus_arbiter;
    import tm1638_pkg::*;

    localparam int unsigned N       = 3;
    localparam int unsigned GAP_MIN = 28;
    localparam int unsigned WDOG    = 1024;

    typedef struct {
        logic [7:0] din;
        logic       rw;
        logic       chk_din;
    } latch_t;

    logic               clk = 1'b0;
    logic               rst;
    logic [N-1:0]       req;
    logic [N-1:0][7:0]  req_cmd;
    logic [N-1:0][4:0]  req_len;
    logic [N-1:0]       req_rd;
    logic [N-1:0][7:0]  wr_data;
    logic [N-1:0]       gnt;
    logic               wr_take;
    logic [7:0]         rd_data;
    logic               rd_valid;
    logic               done;
    logic               err;
    logic               sio_latch;
    logic [7:0]         sio_din;
    logic               sio_rw;
    logic               sio_busy;
    logic [7:0]         sio_dout;
    logic               sio_stb;

    int checks   = 0;
    int failures = 0;

    latch_t       latch_q[$];
    logic [7:0]   rdv_q[$];
    logic [7:0]   eng_q[$];
    logic [N-1:0] gnt_q[$];
    logic [N-1:0] done_q[$];
    int           err_exp  = 0;
    int           wr_takes = 0;
    logic         stuck    = 1'b0;
    logic [7:0]   wr_seq[16];
    int           wptr     = 0;

    tm1638_bus_arbiter dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .req_cmd   (req_cmd),
        .req_len   (req_len),
        .req_rd    (req_rd),
        .wr_data   (wr_data),
        .gnt       (gnt),
        .wr_take   (wr_take),
        .rd_data   (rd_data),
        .rd_valid  (rd_valid),
        .done      (done),
        .err       (err),
        .sio_latch (sio_latch),
        .sio_din   (sio_din),
        .sio_rw    (sio_rw),
        .sio_busy  (sio_busy),
        .sio_dout  (sio_dout),
        .sio_stb   (sio_stb)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    // Byte engine: busy for three cycles after each latch; read bytes come from eng_q.
    initial begin
        int busy_cnt;
        busy_cnt = 0;
        sio_busy = 1'b0;
        sio_dout = 8'h00;
        forever begin
            @(posedge clk);
            #1;
            if (stuck) begin
                sio_busy = 1'b1;
            end else if (busy_cnt > 0) begin
                busy_cnt--;
                if (busy_cnt == 0) sio_busy = 1'b0;
            end else if (sio_latch === 1'b1) begin
                sio_busy = 1'b1;
                busy_cnt = 3;
                if (sio_rw === 1'b0 && eng_q.size() > 0) sio_dout = eng_q.pop_front();
            end else begin
                sio_busy = 1'b0;
            end
        end
    end

    // Write source: advance to the next byte after each wr_take.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (wr_take === 1'b1 && wptr < 15) begin
                wptr++;
                wr_data = {N{wr_seq[wptr]}};
            end
        end
    end

    // Monitor: pops expectations whenever the DUT presents an event.
    initial begin
        latch_t       l;
        logic [N-1:0] prev_gnt;
        logic [N-1:0] last_gnt;
        logic         prev_stb;
        int           high_cnt;
        prev_gnt = '0;
        last_gnt = '0;
        prev_stb = 1'b0;
        high_cnt = 0;
        forever begin
            @(negedge clk);
            if (rst === 1'b0) begin
                if (sio_latch === 1'b1) begin
                    if (latch_q.size() == 0) chk("latch_expected", 32'(latch_q.size() != 0), 32'd1);
                    else begin
                        l = latch_q.pop_front();
                        chk("latch_rw", 32'(sio_rw), 32'(l.rw));
                        if (l.chk_din) chk("latch_din", 32'(sio_din), 32'(l.din));
                        chk("latch_stb_low", 32'(sio_stb), 32'd0);
                    end
                end
                if (wr_take === 1'b1) wr_takes++;
                if (rd_valid === 1'b1) begin
                    if (rdv_q.size() == 0) chk("rd_expected", 32'(rdv_q.size() != 0), 32'd1);
                    else chk("rd_data", 32'(rd_data), 32'(rdv_q.pop_front()));
                end
                if (gnt !== '0 && prev_gnt === '0) begin
                    if (gnt_q.size() == 0) chk("gnt_expected", 32'(gnt_q.size() != 0), 32'd1);
                    else chk("gnt_order", 32'(gnt), 32'(gnt_q.pop_front()));
                end
                if (done === 1'b1) begin
                    if (done_q.size() == 0) chk("done_expected", 32'(done_q.size() != 0), 32'd1);
                    else begin
                        chk("done_owner", 32'(last_gnt), 32'(done_q.pop_front()));
                        chk("done_stb_high", 32'(sio_stb), 32'd1);
                        chk("done_gnt_clear", 32'(gnt), 32'd0);
                    end
                end
                if (err === 1'b1) begin
                    chk("err_expected", 32'(err_exp > 0), 32'd1);
                    if (err_exp > 0) err_exp--;
                    chk("err_stb_high", 32'(sio_stb), 32'd1);
                end
            end
            if (gnt !== '0) last_gnt = gnt;
            prev_gnt = gnt;
            if (sio_stb === 1'b1) begin
                high_cnt++;
            end else if (sio_stb === 1'b0 && prev_stb === 1'b1) begin
                chk("stb_gap", 32'(high_cnt >= GAP_MIN), 32'd1);
                high_cnt = 0;
            end
            prev_stb = sio_stb;
        end
    end

    task automatic push_latch(input logic [7:0] din, input logic rw, input logic chk_din);
        latch_t l;
        l.din     = din;
        l.rw      = rw;
        l.chk_din = chk_din;
        latch_q.push_back(l);
    endtask

    task automatic reset_wr();
        wptr    = 0;
        wr_data = {N{wr_seq[0]}};
    endtask

    task automatic wait_gnt(input int budget);
        int n;
        n = 0;
        while (gnt === '0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk("gnt_timeout", 32'(gnt !== '0), 32'd1);
    endtask

    task automatic wait_done(input int count, input int budget);
        int seen;
        int n;
        seen = 0;
        n    = 0;
        while (seen < count && n < budget) begin
            @(negedge clk);
            n++;
            if (done === 1'b1) seen++;
        end
        chk("done_count", 32'(seen), 32'(count));
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        req = '0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        int n;
        rst     = 1'b1;
        req     = '0;
        req_cmd = '0;
        req_len = '0;
        req_rd  = '0;
        for (int i = 0; i < 16; i++) wr_seq[i] = 8'h00;
        reset_wr();

        // Reset values.
        repeat (3) @(posedge clk);
        #1;
        chk("rst_stb", 32'(sio_stb), 32'd1);
        chk("rst_rw", 32'(sio_rw), 32'd1);
        chk("rst_latch", 32'(sio_latch), 32'd0);
        chk("rst_din", 32'(sio_din), 32'd0);
        chk("rst_gnt", 32'(gnt), 32'd0);
        chk("rst_wr_take", 32'(wr_take), 32'd0);
        chk("rst_rd_valid", 32'(rd_valid), 32'd0);
        chk("rst_rd_data", 32'(rd_data), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        rst = 1'b0;

        // Single write frame on requester 0.
        req_cmd[0] = CMD_ADDR0;
        req_len[0] = 5'd2;
        req_rd[0]  = 1'b0;
        wr_seq[0]  = 8'h3F;
        wr_seq[1]  = 8'h06;
        reset_wr();
        wr_takes = 0;
        gnt_q.push_back(3'b001);
        push_latch(8'hC0, 1'b1, 1'b1);
        push_latch(8'h3F, 1'b1, 1'b1);
        push_latch(8'h06, 1'b1, 1'b1);
        done_q.push_back(3'b001);
        @(negedge clk);
        req = 3'b001;
        wait_gnt(100);
        req = '0;
        wait_done(1, 500);
        chk("t1_wr_takes", 32'(wr_takes), 32'd2);

        // Read keys on requester 1.
        req_cmd[1] = CMD_READ_KEYS;
        req_len[1] = 5'd4;
        req_rd[1]  = 1'b1;
        wr_takes   = 0;
        eng_q.push_back(8'h01); eng_q.push_back(8'h10);
        eng_q.push_back(8'h00); eng_q.push_back(8'h11);
        rdv_q.push_back(8'h01); rdv_q.push_back(8'h10);
        rdv_q.push_back(8'h00); rdv_q.push_back(8'h11);
        gnt_q.push_back(3'b010);
        push_latch(CMD_READ_KEYS, 1'b1, 1'b1);
        for (int i = 0; i < 4; i++) push_latch(8'h00, 1'b0, 1'b0);
        done_q.push_back(3'b010);
        @(negedge clk);
        req = 3'b010;
        wait_gnt(100);
        req = '0;
        wait_done(1, 500);
        chk("t2_wr_takes", 32'(wr_takes), 32'd0);
        chk("t2_rd_drained", 32'(rdv_q.size()), 32'd0);

        // Contention from a fresh pointer: order 0,1,2,0.
        do_reset();
        req_cmd[0] = CMD_WRITE_DISP;
        req_cmd[1] = CMD_DISP_ON;
        req_cmd[2] = CMD_ADDR0;
        req_len    = '0;
        req_rd     = '0;
        gnt_q.push_back(3'b001); gnt_q.push_back(3'b010);
        gnt_q.push_back(3'b100); gnt_q.push_back(3'b001);
        push_latch(CMD_WRITE_DISP, 1'b1, 1'b1);
        push_latch(CMD_DISP_ON, 1'b1, 1'b1);
        push_latch(CMD_ADDR0, 1'b1, 1'b1);
        push_latch(CMD_WRITE_DISP, 1'b1, 1'b1);
        done_q.push_back(3'b001); done_q.push_back(3'b010);
        done_q.push_back(3'b100); done_q.push_back(3'b001);
        @(negedge clk);
        req = 3'b111;
        wait_done(4, 2000);
        req = '0;
        repeat (40) @(negedge clk);
        chk("t3_no_extra_grant", 32'(gnt), 32'd0);

        // Reset during the second data byte of a len-8 write (pointer now at 1).
        req_cmd[1] = CMD_WRITE_DISP;
        req_len[1] = 5'd8;
        req_rd[1]  = 1'b0;
        for (int i = 0; i < 8; i++) wr_seq[i] = 8'(8'h11 * (i + 1));
        reset_wr();
        gnt_q.push_back(3'b010);
        push_latch(CMD_WRITE_DISP, 1'b1, 1'b1);
        push_latch(8'h11, 1'b1, 1'b1);
        push_latch(8'h22, 1'b1, 1'b1);
        @(negedge clk);
        req = 3'b010;
        wait_gnt(100);
        req = '0;
        n = 0;
        for (int c = 0; c < 400 && n < 3; c++) begin
            @(negedge clk);
            if (sio_latch === 1'b1) n++;
        end
        chk("t4_reached_byte2", 32'(n), 32'd3);
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("t4_stb", 32'(sio_stb), 32'd1);
        chk("t4_gnt", 32'(gnt), 32'd0);
        chk("t4_done", 32'(done), 32'd0);
        chk("t4_latch", 32'(sio_latch), 32'd0);
        rst = 1'b0;
        n = 0;
        repeat (60) begin
            @(negedge clk);
            if (done === 1'b1) n++;
        end
        chk("t4_no_done", 32'(n), 32'd0);
        req_cmd[2] = CMD_ADDR0;
        req_len[2] = 5'd1;
        req_rd[2]  = 1'b0;
        wr_seq[0]  = 8'hAA;
        reset_wr();
        wr_takes = 0;
        gnt_q.push_back(3'b100);
        push_latch(CMD_ADDR0, 1'b1, 1'b1);
        push_latch(8'hAA, 1'b1, 1'b1);
        done_q.push_back(3'b100);
        @(negedge clk);
        req = 3'b100;
        wait_gnt(100);
        req = '0;
        wait_done(1, 500);
        chk("t4_wr_takes", 32'(wr_takes), 32'd1);

        // Engine stuck busy during the command byte.
        stuck      = 1'b1;
        req_cmd[0] = CMD_DISP_ON;
        req_len[0] = 5'd0;
        req_rd[0]  = 1'b0;
        gnt_q.push_back(3'b001);
        push_latch(CMD_DISP_ON, 1'b1, 1'b1);
        @(negedge clk);
        req = 3'b001;
        wait_gnt(100);
        req = '0;
        n = 0;
        for (int c = 0; c < 200 && n == 0; c++) begin
            @(negedge clk);
            if (sio_latch === 1'b1) n++;
        end
        chk("t5_cmd_latched", 32'(n), 32'd1);
`ifdef TM1638_ARB_WDOG_EN
        err_exp = 1;
        n = 0;
        while (err !== 1'b1 && n < 1200) begin
            @(negedge clk);
            n++;
        end
        chk("t5_err_latency", 32'(n), 32'(WDOG));
        chk("t5_err_stb", 32'(sio_stb), 32'd1);
        @(negedge clk);
        chk("t5_err_gnt", 32'(gnt), 32'd0);
        repeat (50) @(negedge clk);
`else
        n = 0;
        repeat (WDOG + 200) begin
            @(negedge clk);
            if (err === 1'b1) n++;
        end
        chk("t5_no_err", 32'(n), 32'd0);
        chk("t5_stb_low", 32'(sio_stb), 32'd0);
        chk("t5_gnt_held", 32'(gnt), 32'd1);
`endif
        stuck = 1'b0;
        do_reset();
        repeat (5) @(negedge clk);

        chk("end_latch_q", 32'(latch_q.size()), 32'd0);
        chk("end_rd_q", 32'(rdv_q.size()), 32'd0);
        chk("end_gnt_q", 32'(gnt_q.size()), 32'd0);
        chk("end_done_q", 32'(done_q.size()), 32'd0);
        chk("end_err_exp", 32'(err_exp), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
